wb_uart_arbiter: RTL and testbench

Two-master, round-robin Wishbone arbiter that shares a single UART_16550 register port between the AHB-to-FPGA bridge path (master 0) and a fabric-side UART traffic engine (master 1). It sits between the chip-select/decode logic of the FPGA IP top level and one UART_16550 instance. It sequences one transfer at a time, routes ACK and read data back to the granted master, and enforces a bus timeout so that a hung slave cannot stall either master.

---
 rtl/wb_uart_arb_pkg.sv | 22 ++
 rtl/wb_arb_timeout_cntr.sv | 39 +++
 rtl/wb_uart_arbiter.sv | 157 +++++++++++++++
 tb/tb_wb_uart_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_uart_arb_pkg
// Shared types and constants for the two-master UART Wishbone arbiter.
//   arb_state_t            : arbiter FSM state encoding
//   GNT_NONE/GNT_M0/GNT_M1 : one-hot grant encodings driven on GRANT_o
//   DEFAULT_TIMEOUT_VALUE  : read data returned to a master on a bus timeout
// ---------------------------------------------------------------------------
package wb_uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam logic [15:0] DEFAULT_TIMEOUT_VALUE = 16'hBAD0;

endpackage : wb_uart_arb_pkg

// File: rtl/wb_arb_timeout_cntr.sv
// ---------------------------------------------------------------------------
// wb_arb_timeout_cntr
// Counts cycles spent waiting for a slave acknowledge.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear (has priority over en)
//   en    : count enable
//   tc    : terminal count, high while enabled at count == TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module wb_arb_timeout_cntr #(
    parameter int CNTR_WIDTH     = 7,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNTR_WIDTH-1:0] TC_VALUE = CNTR_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNTR_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Qualified by en so a stale count can never fire outside the wait window.
    assign tc = en && (count == TC_VALUE);

endmodule : wb_arb_timeout_cntr

// File: rtl/wb_uart_arbiter.sv
// ---------------------------------------------------------------------------
// wb_uart_arbiter
// Round-robin arbiter sharing one UART_16550 Wishbone register port between
// the AHB bridge path (master 0) and a fabric traffic engine (master 1).
// One transfer at a time: IDLE -> BUSY -> RELEASE -> IDLE. A timeout stops a
// hung slave from stalling either master.
// Ports:
//   WBs_CLK_i, WBs_RST_N_i : clock and asynchronous active-low reset
//   Mx_ADR/CYC/STB/WE/DAT_i: master x request
//   Mx_DAT_o, Mx_ACK_o     : read data and acknowledge to master x
//   S_*_o / S_DAT_i/S_ACK_i: UART slave port
//   GRANT_o                : one-hot current grant, 00 when idle
//   TMO_FLAG_o, TMO_CLR_i  : sticky per-master timeout flags and their clear
// ---------------------------------------------------------------------------
module wb_uart_arbiter
    import wb_uart_arb_pkg::*;
#(
    parameter int                    ADRWIDTH       = 4,
    parameter int                    WDATAWIDTH     = 8,
    parameter int                    RDATAWIDTH     = 16,
    parameter int                    TIMEOUT_CYCLES = 64,
    parameter int                    CNTR_WIDTH     = 7,
    parameter logic [RDATAWIDTH-1:0] TIMEOUT_VALUE  = RDATAWIDTH'(DEFAULT_TIMEOUT_VALUE)
) (
    input  logic                  WBs_CLK_i,
    input  logic                  WBs_RST_N_i,

    input  logic [ADRWIDTH-1:0]   M0_ADR_i,
    input  logic                  M0_CYC_i,
    input  logic                  M0_STB_i,
    input  logic                  M0_WE_i,
    input  logic [WDATAWIDTH-1:0] M0_DAT_i,
    output logic [RDATAWIDTH-1:0] M0_DAT_o,
    output logic                  M0_ACK_o,

    input  logic [ADRWIDTH-1:0]   M1_ADR_i,
    input  logic                  M1_CYC_i,
    input  logic                  M1_STB_i,
    input  logic                  M1_WE_i,
    input  logic [WDATAWIDTH-1:0] M1_DAT_i,
    output logic [RDATAWIDTH-1:0] M1_DAT_o,
    output logic                  M1_ACK_o,

    output logic [ADRWIDTH-1:0]   S_ADR_o,
    output logic                  S_CYC_o,
    output logic                  S_STB_o,
    output logic                  S_WE_o,
    output logic [WDATAWIDTH-1:0] S_DAT_o,
    input  logic [RDATAWIDTH-1:0] S_DAT_i,
    input  logic                  S_ACK_i,

    output logic [1:0]            GRANT_o,
    output logic [1:0]            TMO_FLAG_o,
    input  logic                  TMO_CLR_i
);

    arb_state_t state;
    logic [1:0] grant;
    logic       rr;          // 0: master 0 wins a tie, 1: master 1 wins
    logic [1:0] tmo_flag;

    logic req0, req1, busy, tc, tmo, bus_exit;

    // Fields of the currently granted master; grant is one-hot in BUSY.
    logic                  g_cyc, g_stb, g_we;
    logic [ADRWIDTH-1:0]   g_adr;
    logic [WDATAWIDTH-1:0] g_dat;

    assign req0 = M0_CYC_i & M0_STB_i;
    assign req1 = M1_CYC_i & M1_STB_i;
    assign busy = (state == BUSY);

    assign g_cyc = grant[1] ? M1_CYC_i : M0_CYC_i;
    assign g_stb = grant[1] ? M1_STB_i : M0_STB_i;
    assign g_we  = grant[1] ? M1_WE_i  : M0_WE_i;
    assign g_adr = grant[1] ? M1_ADR_i : M0_ADR_i;
    assign g_dat = grant[1] ? M1_DAT_i : M0_DAT_i;

    // The counter holds at zero outside BUSY, so it starts from zero on every
    // entry to BUSY.
    wb_arb_timeout_cntr #(
        .CNTR_WIDTH     (CNTR_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo_cntr (
        .clk   (WBs_CLK_i),
        .rst_n (WBs_RST_N_i),
        .clr   (~busy),
        .en    (busy),
        .tc    (tc)
    );

    // A slave ACK on the terminal cycle wins over the timeout.
    assign tmo      = tc & ~S_ACK_i;
    assign bus_exit = busy & (S_ACK_i | tmo | ~g_cyc);

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_N_i) begin
        if (!WBs_RST_N_i) begin
            state <= IDLE;
            grant <= GNT_NONE;
            rr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        state <= BUSY;
                        if (req0 && (!req1 || !rr)) begin
                            grant <= GNT_M0;
                        end else begin
                            grant <= GNT_M1;
                        end
                    end
                end
                BUSY: begin
                    if (bus_exit) begin
                        state <= RELEASE;
                        grant <= GNT_NONE;
                        // Favour the other master next time, whatever ended the transfer.
                        rr    <= ~grant[1];
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    grant <= GNT_NONE;
                end
            endcase
        end
    end

    // A new timeout beats a simultaneous clear.
    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_N_i) begin
        if (!WBs_RST_N_i) begin
            tmo_flag <= 2'b00;
        end else begin
            tmo_flag <= (TMO_CLR_i ? 2'b00 : tmo_flag) | (tmo ? grant : 2'b00);
        end
    end

    // S_CYC_o is dropped on the timeout cycle to abandon the hung access;
    // S_STB_o stays a plain mux of the granted master.
    assign S_CYC_o = busy & g_cyc & ~tmo;
    assign S_STB_o = busy & g_stb;
    assign S_WE_o  = busy & g_we;
    assign S_ADR_o = busy ? g_adr : '0;
    assign S_DAT_o = busy ? g_dat : '0;

    assign M0_ACK_o = busy & grant[0] & (S_ACK_i | tmo);
    assign M1_ACK_o = busy & grant[1] & (S_ACK_i | tmo);
    assign M0_DAT_o = grant[0] ? (tmo ? TIMEOUT_VALUE : S_DAT_i) : '0;
    assign M1_DAT_o = grant[1] ? (tmo ? TIMEOUT_VALUE : S_DAT_i) : '0;

    assign GRANT_o    = grant;
    assign TMO_FLAG_o = tmo_flag;

endmodule : wb_uart_arbiter

// File: tb/tb_wb_uart_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_uart_arbiter
// Scoreboard bench: expected ACKs are queued as requests are issued and
// popped by a monitor when either master sees an acknowledge.
// ---------------------------------------------------------------------------
module tb_wb_uart_arbiter;
    import wb_uart_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  M0_ADR_i, M1_ADR_i;
    logic        M0_CYC_i, M0_STB_i, M0_WE_i, M1_CYC_i, M1_STB_i, M1_WE_i;
    logic [7:0]  M0_DAT_i, M1_DAT_i;
    logic [15:0] M0_DAT_o, M1_DAT_o;
    logic        M0_ACK_o, M1_ACK_o;
    logic [3:0]  S_ADR_o;
    logic        S_CYC_o, S_STB_o, S_WE_o;
    logic [7:0]  S_DAT_o;
    logic [15:0] S_DAT_i;
    logic        S_ACK_i;
    logic [1:0]  GRANT_o, TMO_FLAG_o;
    logic        TMO_CLR_i;

    always #5 clk = ~clk;

    wb_uart_arbiter dut (
        .WBs_CLK_i  (clk),      .WBs_RST_N_i(rst_n),
        .M0_ADR_i   (M0_ADR_i), .M0_CYC_i   (M0_CYC_i), .M0_STB_i(M0_STB_i),
        .M0_WE_i    (M0_WE_i),  .M0_DAT_i   (M0_DAT_i), .M0_DAT_o(M0_DAT_o),
        .M0_ACK_o   (M0_ACK_o),
        .M1_ADR_i   (M1_ADR_i), .M1_CYC_i   (M1_CYC_i), .M1_STB_i(M1_STB_i),
        .M1_WE_i    (M1_WE_i),  .M1_DAT_i   (M1_DAT_i), .M1_DAT_o(M1_DAT_o),
        .M1_ACK_o   (M1_ACK_o),
        .S_ADR_o    (S_ADR_o),  .S_CYC_o    (S_CYC_o),  .S_STB_o (S_STB_o),
        .S_WE_o     (S_WE_o),   .S_DAT_o    (S_DAT_o),  .S_DAT_i (S_DAT_i),
        .S_ACK_i    (S_ACK_i),
        .GRANT_o    (GRANT_o),  .TMO_FLAG_o (TMO_FLAG_o), .TMO_CLR_i(TMO_CLR_i)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          m;
        logic [15:0] d;
    } exp_t;
    exp_t sb[$];

    int          rr_exp      = 0;   // reference round-robin pointer
    int          slave_wait  = 0;   // wait cycles before ACK, -1 = never ACK
    logic [15:0] slave_rdata = 16'h0000;

    // Slave model: counts strobed cycles, ACKs for one cycle after slave_wait.
    initial begin
        int wcnt;
        wcnt    = 0;
        S_ACK_i = 1'b0;
        S_DAT_i = 16'h0000;
        forever begin
            @(negedge clk);
            if (S_ACK_i) begin
                S_ACK_i = 1'b0;
                S_DAT_i = 16'h0000;
                wcnt    = 0;
            end else if (S_STB_o) begin
                if (slave_wait >= 0 && wcnt == slave_wait) begin
                    S_ACK_i = 1'b1;
                    S_DAT_i = slave_rdata;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: every master ACK must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (M0_ACK_o || M1_ACK_o) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_ack", {30'd0, M1_ACK_o, M0_ACK_o}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("ack_m0", M0_ACK_o, (e.m == 0));
                    check_val("ack_m1", M1_ACK_o, (e.m == 1));
                    check_val("ack_dat", (e.m == 1) ? M1_DAT_o : M0_DAT_o, e.d);
                    check_val("other_dat", (e.m == 1) ? M0_DAT_o : M1_DAT_o, 32'd0);
                    $display("txn m=%0d dat=%h t=%0t", e.m, (e.m == 1) ? M1_DAT_o : M0_DAT_o, $time);
                end
            end
        end
    end

    task automatic drive(input int m, input logic cyc, input logic we,
                         input logic [3:0] adr, input logic [7:0] dat);
        if (m == 0) begin
            M0_CYC_i = cyc; M0_STB_i = cyc; M0_WE_i = we; M0_ADR_i = adr; M0_DAT_i = dat;
        end else begin
            M1_CYC_i = cyc; M1_STB_i = cyc; M1_WE_i = we; M1_ADR_i = adr; M1_DAT_i = dat;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one request and hold it until the master's ACK; lat counts the
    // negedges from the request to the ACK.
    task automatic do_req(input int m, input logic we, input logic [3:0] adr,
                          input logic [7:0] dat, output int lat);
        logic seen;
        seen = 1'b0;
        lat  = -1;
        drive(m, 1'b1, we, adr, dat);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            #1;
            if ((m == 0 && M0_ACK_o) || (m == 1 && M1_ACK_o)) begin
                seen = 1'b1;
                lat  = k;
                break;
            end
        end
        check_val($sformatf("ack_seen_m%0d", m), seen, 1);
        rr_exp = 1 - m;
        @(negedge clk);
        drive(m, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic watch_bus(input logic [1:0] gnt, input logic [3:0] adr,
                             input logic [7:0] dat, input logic we);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (S_STB_o) begin
                seen = 1'b1;
                break;
            end
        end
        check_val("bus_seen", seen, 1);
        check_val("grant", GRANT_o, gnt);
        check_val("s_cyc", S_CYC_o, 1);
        check_val("s_adr", S_ADR_o, adr);
        check_val("s_dat", S_DAT_o, dat);
        check_val("s_we", S_WE_o, we);
    endtask

    // Both masters request together; order follows the reference RR pointer.
    task automatic both_req(input int wait_cycles, input logic [15:0] rdata);
        int   l0, l1, first;
        exp_t e;
        slave_wait  = wait_cycles;
        slave_rdata = rdata;
        first = rr_exp;
        e.m = first;     e.d = rdata; sb.push_back(e);
        e.m = 1 - first; e.d = rdata; sb.push_back(e);
        fork
            do_req(0, 1'b1, 4'h1, 8'h11, l0);
            do_req(1, 1'b1, 4'h2, 8'h22, l1);
            watch_bus((first == 0) ? GNT_M0 : GNT_M1, (first == 0) ? 4'h1 : 4'h2,
                      (first == 0) ? 8'h11 : 8'h22, 1'b1);
        join
        check_val("both_first_lat", (first == 0) ? l0 : l1, wait_cycles + 1);
        check_val("both_second_lat", (first == 0) ? l1 : l0, 2 * (wait_cycles + 1) + 2);
        idle(2);
    endtask

    initial begin
        int   lat;
        exp_t e;
        rst_n     = 1'b0;
        TMO_CLR_i = 1'b0;
        drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
        idle(3);
        #1;
        check_val("rst_grant", GRANT_o, 0);
        check_val("rst_flag", TMO_FLAG_o, 0);
        check_val("rst_s_cyc", S_CYC_o, 0);
        check_val("rst_m0_ack", M0_ACK_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Simultaneous requests from reset: M0 first.
        both_req(0, 16'h00A5);

        // M0 write, slave with two wait states.
        slave_wait = 2; slave_rdata = 16'h0000;
        e.m = 0; e.d = 16'h0000; sb.push_back(e);
        fork
            do_req(0, 1'b1, 4'h3, 8'h83, lat);
            watch_bus(GNT_M0, 4'h3, 8'h83, 1'b1);
        join
        check_val("wr_lat", lat, 3);
        #1;
        check_val("wr_grant_after", GRANT_o, 0);
        check_val("wr_m1_ack", M1_ACK_o, 0);
        idle(2);

        // RR now favours M1.
        both_req(1, 16'h5A5A);

        // M1 read ADR 5.
        slave_wait = 1; slave_rdata = 16'h0060;
        e.m = 1; e.d = 16'h0060; sb.push_back(e);
        fork
            do_req(1, 1'b0, 4'h5, 8'h00, lat);
            watch_bus(GNT_M1, 4'h5, 8'h00, 1'b0);
        join
        #1;
        check_val("rd_m1_dat_after", M1_DAT_o, 0);
        idle(2);

        // Hung slave: timeout on the 64th BUSY cycle.
        slave_wait = -1;
        e.m = 0; e.d = 16'hBAD0; sb.push_back(e);
        do_req(0, 1'b0, 4'h1, 8'h00, lat);
        check_val("tmo_lat", lat, 64);
        #1;
        check_val("tmo_flag_set", TMO_FLAG_o, 2'b01);
        idle(2);
        TMO_CLR_i = 1'b1;
        @(negedge clk);
        TMO_CLR_i = 1'b0;
        #1;
        check_val("tmo_flag_clr", TMO_FLAG_o, 2'b00);

        // Slave ACK coincident with terminal count: data wins, no flag.
        slave_wait = 63; slave_rdata = 16'h1234;
        e.m = 1; e.d = 16'h1234; sb.push_back(e);
        do_req(1, 1'b0, 4'h7, 8'h00, lat);
        check_val("coinc_lat", lat, 64);
        idle(2);
        #1;
        check_val("coinc_flag", TMO_FLAG_o, 2'b00);

        // M0 aborts mid-BUSY: no ACK, RR moves to M1.
        slave_wait = -1;
        drive(0, 1'b1, 1'b0, 4'h2, 8'h00);
        idle(5);
        drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
        idle(3);
        #1;
        check_val("abort_grant", GRANT_o, 0);
        rr_exp = 1;
        both_req(0, 16'h0F0F);

        // Reset during BUSY drops everything immediately.
        slave_wait = -1;
        drive(1, 1'b1, 1'b1, 4'h9, 8'h99);
        idle(3);
        #1;
        check_val("pre_rst_stb", S_STB_o, 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_grant", GRANT_o, 0);
        check_val("mid_rst_s_cyc", S_CYC_o, 0);
        check_val("mid_rst_s_adr", S_ADR_o, 0);
        check_val("mid_rst_m1_ack", M1_ACK_o, 0);
        drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
        idle(2);
        rst_n = 1'b1;
        rr_exp = 0;
        idle(2);
        both_req(0, 16'h0042);

        check_val("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wb_uart_arbiter
